// File: rtl/eight_bit.sv
// 8-bit ripple-carry adder with carry-in/carry-out and a registered result.
// One-cycle latency; a synchronous active-high reset clears the output register.
module eight_bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       c
);

  logic [8:0] carry;
  logic [7:0] sum;

  assign carry[0] = cin;

  // One full-adder cell per bit; each carry feeds the next stage.
  for (genvar i = 0; i < 8; i++) begin : g_fa
    logic p;
    assign p            = a[i] ^ b[i];
    assign sum[i]       = p ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & p);
  end

  logic [7:0] s_q, s_d;
  logic       c_q, c_d;

  always_comb begin
    s_d = sum;
    c_d = carry[8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= 8'd0;
      c_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s = s_q;
  assign c = c_q;

endmodule

// File: tb/tb_eight_bit.sv
// Self-checking bench for eight_bit: directed literal vectors plus a per-cycle
// comparison against an arithmetic model of the registered 9-bit sum.
module tb_eight_bit;

  logic       clk;
  logic       rst;
  logic [7:0] a, b;
  logic       cin;
  logic [7:0] s;
  logic       c;

  int checks   = 0;
  int failures = 0;

  eight_bit dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .cin (cin),
    .s   (s),
    .c   (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the output after an edge is the 9-bit sum of the operands seen at
  // that edge, or zero when reset was high.
  logic [8:0] model_q;
  bit         model_valid = 1'b0;

  always @(posedge clk) begin
    model_q     <= rst ? 9'd0 : ({1'b0, a} + {1'b0, b} + {8'd0, cin});
    model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if ({c, s} !== model_q) begin
        failures++;
        $display("FAIL model_cmp t=%0t got c=%0b s=%0d want c=%0b s=%0d",
                 $time, c, s, model_q[8], model_q[7:0]);
      end
    end
  end

  task automatic apply(input string name, input logic r, input logic [7:0] av,
                       input logic [7:0] bv, input logic ci,
                       input logic [7:0] exp_s, input logic exp_c);
    rst = r;
    a   = av;
    b   = bv;
    cin = ci;
    @(posedge clk);
    #1;
    checks++;
    if (s !== exp_s || c !== exp_c) begin
      failures++;
      $display("FAIL %s got c=%0b s=%0d want c=%0b s=%0d", name, c, s, exp_c, exp_s);
    end
  endtask

  initial begin
    rst = 1'b1;
    a   = 8'd236;
    b   = 8'd34;
    cin = 1'b0;

    apply("reset_edge1", 1'b1, 8'd236, 8'd34, 1'b0, 8'd0, 1'b0);
    apply("reset_edge2", 1'b1, 8'd236, 8'd34, 1'b0, 8'd0, 1'b0);
    apply("wrap_270",    1'b0, 8'd236, 8'd34, 1'b0, 8'd14, 1'b1);
    apply("sum_133",     1'b0, 8'd99,  8'd34, 1'b0, 8'd133, 1'b0);
    apply("sum_166",     1'b0, 8'd99,  8'd67, 1'b0, 8'd166, 1'b0);
    apply("full_ripple", 1'b0, 8'd255, 8'd0,  1'b1, 8'd0, 1'b1);
    apply("max_case",    1'b0, 8'd255, 8'd255, 1'b1, 8'd255, 1'b1);
    apply("min_case",    1'b0, 8'd0,   8'd0,  1'b0, 8'd0, 1'b0);
    apply("cin_only",    1'b0, 8'd0,   8'd0,  1'b1, 8'd1, 1'b0);
    apply("alt_bits",    1'b0, 8'hAA,  8'h55, 1'b1, 8'd0, 1'b1);
    apply("midrst",      1'b1, 8'd200, 8'd100, 1'b1, 8'd0, 1'b0);
    apply("after_rst",   1'b0, 8'd128, 8'd128, 1'b0, 8'd0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      rst = (i == 300 || i == 301 || i == 650);
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
